// File: rtl/enc_pkg.sv
// enc_pkg: format tags, default NOP word and immediate range limits for the instruction encoder.
package enc_pkg;
    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_S = 3'd1;
    localparam logic [2:0] FMT_B = 3'd2;
    localparam logic [2:0] FMT_J = 3'd3;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
    localparam logic signed [63:0] IS_MIN = -64'sd2048;
    localparam logic signed [63:0] IS_MAX = 64'sd2047;
    localparam logic signed [63:0] B_MIN = -64'sd4096;
    localparam logic signed [63:0] B_MAX = 64'sd4094;
    localparam logic signed [63:0] J_MIN = -64'sd1048576;
    localparam logic signed [63:0] J_MAX = 64'sd1048574;
endpackage

// File: rtl/imm_range_check.sv
// imm_range_check: flags immediates outside their format's range, odd branch/jump offsets and reserved formats.
module imm_range_check
    import enc_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [63:0] i_imm,
    output logic        o_err
);
    logic signed [63:0] w_imm;
    logic signed [63:0] w_lo;
    logic signed [63:0] w_hi;
    logic               w_even;
    always_comb begin
        w_imm  = i_imm;
        w_lo   = (i_fmt == FMT_B) ? B_MIN : (i_fmt == FMT_J) ? J_MIN : IS_MIN;
        w_hi   = (i_fmt == FMT_B) ? B_MAX : (i_fmt == FMT_J) ? J_MAX : IS_MAX;
        w_even = (i_fmt == FMT_B) || (i_fmt == FMT_J);
        o_err  = (i_fmt > FMT_J) || (w_imm < w_lo) || (w_imm > w_hi) || (w_even && i_imm[0]);
    end
endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: two-stage pipeline that range-checks an immediate and packs it into an RV64 I/S/B/J word.
module inst_encoder
    import enc_pkg::*;
#(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [63:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);
    logic        r_s1_valid;
    logic        r_s1_err;
    logic [2:0]  r_s1_fmt;
    logic [6:0]  r_s1_op;
    logic [2:0]  r_s1_f3;
    logic [4:0]  r_s1_rd;
    logic [4:0]  r_s1_rs1;
    logic [4:0]  r_s1_rs2;
    logic [20:0] r_s1_imm;
    logic        w_err;
    logic        w_s2_adv;
    logic        w_s1_adv;
    logic [31:0] w_inst;

    imm_range_check u_chk (
        .i_fmt (in_fmt),
        .i_imm (in_imm),
        .o_err (w_err)
    );

    assign w_s2_adv = !out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    always_comb begin
        w_inst = (r_s1_fmt == FMT_S) ? {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_imm[4:0], r_s1_op} :
                 (r_s1_fmt == FMT_B) ? {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_f3,
                                        r_s1_imm[4:1], r_s1_imm[11], r_s1_op} :
                 (r_s1_fmt == FMT_J) ? {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12],
                                        r_s1_rd, r_s1_op} :
                                       {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_fmt   <= '0;
            r_s1_op    <= '0;
            r_s1_f3    <= '0;
            r_s1_rd    <= '0;
            r_s1_rs1   <= '0;
            r_s1_rs2   <= '0;
            r_s1_imm   <= '0;
            out_valid  <= 1'b0;
            out_inst   <= '0;
            out_err    <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_err <= w_err;
                    r_s1_fmt <= in_fmt;
                    r_s1_op  <= in_opcode;
                    r_s1_f3  <= in_funct3;
                    r_s1_rd  <= in_rd;
                    r_s1_rs1 <= in_rs1;
                    r_s1_rs2 <= in_rs2;
                    r_s1_imm <= in_imm[20:0];
                end
            end
            if (w_s2_adv) begin
                out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    out_inst <= r_s1_err ? NOP_INST : w_inst;
                    out_err  <= r_s1_err;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (out_valid && out_ready) begin
            if (!out_err && !(&enc_count)) enc_count <= enc_count + 1'b1;
            if (out_err && !(&err_count)) err_count <= err_count + 1'b1;
        end
    end
endmodule
